// File: rtl/n2_writeback_pkg.sv
// Shared types and helpers for the NanoCore writeback stage.
// Holds the skid entry layout and the wrapping uid age compare.
package n2_writeback_pkg;

  localparam int UID_W  = 8;
  localparam int RIDX_W = 5;

  typedef struct packed {
    logic              valid;
    logic [UID_W-1:0]  uid;
    logic [RIDX_W-1:0] dst;
    logic [31:0]       data;
  } wb_entry_t;

  // a is older than b when (a - b) wraps negative
  function automatic logic uid_older(
    input logic [UID_W-1:0] a,
    input logic [UID_W-1:0] b
  );
    logic [UID_W-1:0] d;
    d = a - b;
    return d[UID_W-1];
  endfunction

endpackage

// File: rtl/n2_wb_skid_fifo.sv
// In-order skid FIFO for execute results awaiting the RF write port.
// Ports: push/pop, head entry, fill level, load rd kill/block, rd query.
module n2_wb_skid_fifo
  import n2_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  wb_entry_t               push_e,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    ld_v,
  input  logic [RIDX_W-1:0]       ld_dst,
  input  logic [UID_W-1:0]        ld_uid,
  output logic                    ld_block,
  input  logic [RIDX_W-1:0]       q_idx,
  output logic                    q_hit
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = mem[rd_ptr[PW-1:0]];

  // popped slots have valid cleared, so valid alone marks live entries
  always_comb begin
    ld_block = 1'b0;
    q_hit    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid) begin
        if (mem[i].dst == q_idx)
          q_hit = 1'b1;
        if (ld_v && mem[i].dst == ld_dst &&
            uid_older(ld_uid, mem[i].uid))
          ld_block = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_v && mem[i].valid &&
            mem[i].dst == ld_dst &&
            uid_older(mem[i].uid, ld_uid))
          mem[i].valid <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr[PW-1:0]].valid <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= push_e;
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/n2_writeback.sv
// Writeback/redirect stage: arbitrates execute and load results onto
// the RF write port, skids execute results on collision, and emits
// a registered redirect plus a timed flush window.
// Ports: ex_* execute in, lsu_* load in, rf_* write port out,
// hz_* hazard query, redirect_*/flush_o control out.
// Optional WB_PERF_CNT_EN adds retire_cnt_o and redirect_cnt_o.
module n2_writeback
  import n2_writeback_pkg::*;
#(
  parameter int SKID_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_IDX_W    = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ex_v_i,
  input  logic [7:0]           ex_uid_i,
  input  logic                 ex_rf_we_i,
  input  logic [REG_IDX_W-1:0] ex_rf_dst_i,
  input  logic [31:0]          ex_rst_i,
  input  logic                 ex_is_branch_i,
  input  logic [31:0]          ex_branch_pc_i,
  output logic                 ex_stall_o,
  input  logic                 lsu_v_i,
  input  logic [7:0]           lsu_uid_i,
  input  logic [REG_IDX_W-1:0] lsu_rf_dst_i,
  input  logic [31:0]          lsu_data_i,
  output logic                 rf_we_o,
  output logic [REG_IDX_W-1:0] rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic [7:0]           rf_wuid_o,
  input  logic [REG_IDX_W-1:0] hz_idx_i,
  output logic                 hz_pending_o,
  output logic                 redirect_v_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 flush_o
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]          retire_cnt_o,
  output logic [31:0]          redirect_cnt_o
`endif
);

  localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  logic             ex_acc;
  logic             ld_own;
  logic             ex_same;
  logic             ld_drop;
  logic             push_kill;
  logic             pop;
  logic             push;
  logic             bypass;
  logic             br_take;
  wb_entry_t        push_e;
  wb_entry_t        head;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             fifo_blk;
  logic [FC_W-1:0]  flush_cnt;

  logic                 nxt_we;
  logic [REG_IDX_W-1:0] nxt_addr;
  logic [31:0]          nxt_data;
  logic [7:0]           nxt_uid;

  assign ex_stall_o = full ||
    (count == CNT_W'(SKID_DEPTH - 1) && lsu_v_i);

  assign ex_acc = ex_v_i && ex_rf_we_i &&
                  (ex_rf_dst_i != '0) && !ex_stall_o;
  assign ld_own = lsu_v_i && (lsu_rf_dst_i != '0);

  // an execute result arriving alongside a same-rd load is
  // ordered against it just like a buffered entry
  assign ex_same   = ld_own && ex_acc &&
                     (ex_rf_dst_i == lsu_rf_dst_i);
  assign push_kill = ex_same &&
                     uid_older(ex_uid_i, lsu_uid_i);
  assign ld_drop   = fifo_blk || (ex_same &&
                     uid_older(lsu_uid_i, ex_uid_i));

  assign pop    = !ld_own && !empty;
  assign bypass = !ld_own && empty && ex_acc;
  assign push   = ex_acc && !bypass;

  assign push_e = '{valid: !push_kill,
                    uid:   ex_uid_i,
                    dst:   ex_rf_dst_i,
                    data:  ex_rst_i};

  n2_wb_skid_fifo #(
    .DEPTH(SKID_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_e   (push_e),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .ld_v     (ld_own),
    .ld_dst   (lsu_rf_dst_i),
    .ld_uid   (lsu_uid_i),
    .ld_block (fifo_blk),
    .q_idx    (hz_idx_i),
    .q_hit    (hz_pending_o)
  );

  always_comb begin
    nxt_we   = 1'b0;
    nxt_addr = '0;
    nxt_data = '0;
    nxt_uid  = '0;
    unique case (1'b1)
      ld_own: begin
        nxt_we   = !ld_drop;
        nxt_addr = lsu_rf_dst_i;
        nxt_data = lsu_data_i;
        nxt_uid  = lsu_uid_i;
      end
      pop: begin
        // invalidated entries still burn their slot
        nxt_we   = head.valid;
        nxt_addr = head.dst;
        nxt_data = head.data;
        nxt_uid  = head.uid;
      end
      bypass: begin
        nxt_we   = 1'b1;
        nxt_addr = ex_rf_dst_i;
        nxt_data = ex_rst_i;
        nxt_uid  = ex_uid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      rf_wuid_o  <= '0;
    end else begin
      rf_we_o    <= nxt_we;
      rf_waddr_o <= nxt_we ? nxt_addr : '0;
      rf_wdata_o <= nxt_we ? nxt_data : '0;
      rf_wuid_o  <= nxt_we ? nxt_uid  : '0;
    end
  end

  assign br_take = ex_v_i && ex_is_branch_i;
  assign flush_o = (flush_cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_v_o  <= 1'b0;
      redirect_pc_o <= '0;
      flush_cnt     <= '0;
    end else begin
      redirect_v_o <= br_take;
      if (br_take) begin
        redirect_pc_o <= ex_branch_pc_i;
        flush_cnt     <= FC_W'(FLUSH_CYCLES);
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt_o   <= '0;
      redirect_cnt_o <= '0;
    end else begin
      if (rf_we_o)
        retire_cnt_o <= retire_cnt_o + 64'd1;
      if (redirect_v_o)
        redirect_cnt_o <= redirect_cnt_o + 32'd1;
    end
  end
`endif

endmodule
